// File: rtl/boot_loader_ctrl.sv
// Start-up sequencer: streams host words into data memory with the CPU held in reset,
// then releases the CPU after a fixed settle period.
module boot_loader_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned MAX_WORDS   = 64,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] word_count,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        Ext_MemWrite,
  output logic [31:0] Ext_WriteData,
  output logic [31:0] Ext_DataAdr,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {StIdle, StLoad, StHold, StRun} state_e;

  localparam logic [7:0]  HoldLast = 8'(HOLD_CYCLES - 1);
  localparam logic [16:0] MaxWords = 17'(MAX_WORDS);

  state_e      state_q;
  logic [15:0] count_q;
  logic [15:0] idx_q;
  logic [7:0]  hold_q;
  logic        xfer;

  // Status outputs depend on the registered state only, never on inputs.
  assign in_ready  = (state_q == StLoad);
  assign busy      = (state_q == StLoad) || (state_q == StHold);
  assign done      = (state_q == StRun);
  assign cpu_reset = (state_q != StRun);
  assign xfer      = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      count_q       <= '0;
      idx_q         <= '0;
      hold_q        <= '0;
      err           <= 1'b0;
      Ext_MemWrite  <= 1'b0;
      Ext_WriteData <= '0;
      Ext_DataAdr   <= BASE_ADDR;
    end else begin
      Ext_MemWrite <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if ({1'b0, word_count} > MaxWords) begin
              err <= 1'b1;
            end else if (word_count == 16'd0) begin
              hold_q  <= '0;
              state_q <= StHold;
            end else begin
              count_q <= word_count;
              idx_q   <= '0;
              err     <= 1'b0;
              state_q <= StLoad;
            end
          end
        end
        StLoad: begin
          if (xfer) begin
            Ext_MemWrite  <= 1'b1;
            Ext_WriteData <= in_data;
            Ext_DataAdr   <= BASE_ADDR + {14'd0, idx_q, 2'b00};
            idx_q         <= idx_q + 16'd1;
            // The last word's write lands in the first HOLD cycle, CPU still held.
            if (idx_q == count_q - 16'd1) begin
              hold_q  <= '0;
              state_q <= StHold;
            end
          end
        end
        StHold: begin
          if (hold_q == HoldLast) begin
            state_q <= StRun;
          end else begin
            hold_q <= hold_q + 8'd1;
          end
        end
        StRun: ;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Randomized and directed checks of boot_loader_ctrl against an event-based reference model.
module tb_boot_loader_ctrl;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int MAXW = 64;
  localparam int HOLD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] word_count = '0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready, Ext_MemWrite, cpu_reset, busy, done, err;
  logic [31:0] Ext_WriteData, Ext_DataAdr;

  always #5 clk = ~clk;

  boot_loader_ctrl #(
    .BASE_ADDR  (BASE),
    .MAX_WORDS  (MAXW),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .word_count   (word_count),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .Ext_MemWrite (Ext_MemWrite),
    .Ext_WriteData(Ext_WriteData),
    .Ext_DataAdr  (Ext_DataAdr),
    .cpu_reset    (cpu_reset),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a load is described by how many words it needs, how many were taken,
  // and the edge at which the last one was taken; the CPU runs HOLD edges after that.
  bit          m_valid = 0;
  bit          m_active = 0;
  bit          m_err = 0;
  bit          m_we = 0;
  int          m_need = 0;
  int          m_got = 0;
  longint      m_cyc = 0;
  longint      m_tend = 0;
  logic [31:0] m_data = '0;
  logic [31:0] m_adr = BASE;

  function automatic bit m_loading();
    return m_active && (m_got < m_need);
  endfunction

  function automatic bit m_running();
    return m_active && (m_got == m_need) && (m_cyc >= m_tend + HOLD);
  endfunction

  // Inputs change only just after a rising edge, so at the falling edge they are exactly
  // what the next rising edge will sample: check first, then advance the model by one edge.
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        chk("in_ready", in_ready, m_loading());
        chk("cpu_reset", cpu_reset, !m_running());
        chk("busy", busy, m_active && !m_running());
        chk("done", done, m_running());
        chk("err", err, m_err);
        chk("Ext_MemWrite", Ext_MemWrite, m_we);
        chk("Ext_WriteData", Ext_WriteData, m_data);
        chk("Ext_DataAdr", Ext_DataAdr, m_adr);
      end
      m_cyc++;
      m_valid = 1;
      if (reset) begin
        m_active = 0; m_need = 0; m_got = 0; m_err = 0;
        m_we = 0; m_data = '0; m_adr = BASE;
      end else begin
        m_we = 0;
        if (m_loading() && in_valid) begin
          m_we   = 1;
          m_data = in_data;
          m_adr  = BASE + 32'(4 * m_got);
          m_got++;
          if (m_got == m_need) m_tend = m_cyc;
        end else if (!m_active && start) begin
          if (int'(word_count) > MAXW) begin
            m_err = 1;
          end else begin
            m_active = 1;
            m_need   = int'(word_count);
            m_got    = 0;
            m_tend   = m_cyc;
            if (word_count != 0) m_err = 0;
          end
        end
      end
    end
  end

  // Memory image as the CPU would see it after the load.
  logic [31:0] mem [64];
  int          nwr = 0;
  always @(posedge clk) begin
    if (Ext_MemWrite) begin
      mem[Ext_DataAdr[7:2]] <= Ext_WriteData;
      nwr <= nwr + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1; start = 0; in_valid = 0;
    step();
    reset = 0;
  endtask

  task automatic begin_load(input int wc);
    start = 1; word_count = 16'(wc); in_valid = 0;
    step();
    start = 0;
  endtask

  // mode 0: always valid, 1: random valid, 2: repeating 1,0,0,1
  task automatic feed(input int mode, input int rst_after, input int budget);
    int n;
    bit v;
    n = 0;
    while (!m_running() && n < budget) begin
      unique case (mode)
        0: v = 1;
        1: v = 1'($urandom_range(0, 1));
        default: v = (n % 4 == 0) || (n % 4 == 3);
      endcase
      in_valid = v;
      in_data  = $urandom;
      if (rst_after >= 0 && m_got == rst_after) begin
        reset = 1;
        step();
        reset = 0; in_valid = 0;
        chk("rst in_ready", in_ready, 1'b0);
        chk("rst Ext_MemWrite", Ext_MemWrite, 1'b0);
        chk("rst cpu_reset", cpu_reset, 1'b1);
        chk("rst busy", busy, 1'b0);
        return;
      end
      step();
      n++;
    end
    in_valid = 0;
    total++;
    if (!m_running()) begin
      bad++;
      $display("FAIL load timeout: got done=%0b expected done=1", done);
    end
  endtask

  initial begin
    int w0;
    int wc;
    step();
    do_reset();
    chk("reset cpu_reset", cpu_reset, 1'b1);
    chk("reset Ext_DataAdr", Ext_DataAdr, BASE);

    // Three words back-to-back.
    w0 = nwr;
    begin_load(3);
    in_valid = 1; in_data = 32'hA; step();
    chk("t1 we0", Ext_MemWrite, 1'b1);
    chk("t1 adr0", Ext_DataAdr, 32'h0);
    chk("t1 dat0", Ext_WriteData, 32'hA);
    in_data = 32'hB; step();
    in_data = 32'hC; step();
    in_valid = 0;
    chk("t1 adr2", Ext_DataAdr, 32'h8);
    chk("t1 dat2", Ext_WriteData, 32'hC);
    step(); step(); step();
    chk("t1 held", cpu_reset, 1'b1);
    step();
    chk("t1 released", cpu_reset, 1'b0);
    chk("t1 done", done, 1'b1);
    chk("t1 mem[8]", mem[2], 32'hC);
    chk("t1 writes", 32'(nwr - w0), 32'd3);

    // Start and host traffic in RUN are ignored.
    start = 1; word_count = 16'd2; in_valid = 1; in_data = 32'h1234;
    step(); step();
    start = 0; in_valid = 0;
    chk("run in_ready", in_ready, 1'b0);
    chk("run done", done, 1'b1);
    chk("run we", Ext_MemWrite, 1'b0);

    // Gappy valid: writes only on transfers.
    do_reset();
    w0 = nwr;
    begin_load(2);
    feed(2, -1, 50);
    chk("t2 writes", 32'(nwr - w0), 32'd2);

    // Illegal length, then a legal one clears err.
    do_reset();
    begin_load(65);
    chk("t3 err", err, 1'b1);
    chk("t3 cpu_reset", cpu_reset, 1'b1);
    chk("t3 busy", busy, 1'b0);
    begin_load(1);
    chk("t3 err clr", err, 1'b0);
    feed(0, -1, 50);

    // Zero-length load.
    do_reset();
    begin_load(0);
    step(); step(); step();
    chk("t4 not yet", done, 1'b0);
    step();
    chk("t4 done", done, 1'b1);

    // Reset after two of five words, then a fresh load.
    do_reset();
    begin_load(5);
    feed(0, 2, 50);
    begin_load(5);
    feed(0, -1, 50);

    // Random loads.
    for (int it = 0; it < 30; it++) begin
      do_reset();
      if ($urandom_range(0, 7) == 0) begin
        begin_load($urandom_range(MAXW + 1, 300));
        step();
      end
      wc = $urandom_range(0, MAXW);
      begin_load(wc);
      feed($urandom_range(0, 2),
           ($urandom_range(0, 3) == 0) ? $urandom_range(0, wc) : -1, 600);
      step(); step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
